// File: rtl/button_press_classifier_pkg.sv
// Shared types and helpers for the button front-end (debounce + classifier).
package button_pkg;

  // Gesture FSM states for button_press_classifier.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DOWN1,
    ST_GAP,
    ST_DOWN2,
    ST_LONGHOLD
  } btn_state_t;

  // Milliseconds to clock cycles; integer kHz first so large CLK_HZ stays in range.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Larger of two sizing constants.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Button level in, gesture pulses out. The source side (debouncer or bench)
// uses master; the classifier uses slave.
interface button_press_classifier_if;
  logic btn_clean;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic double_pulse;
  logic long_pulse;
  logic held;

  modport master (
    output btn_clean,
    input  press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, held
  );

  modport slave (
    input  btn_clean,
    output press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, held
  );
endinterface

// File: rtl/button_press_classifier_edge_detect.sv
// Edge detector for the debounced level. The first clock after reset only
// loads prev, so a button already down when reset lifts is not seen as a press.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_clean,
  output logic rise,
  output logic fall,
  output logic level_q
);

  logic prev;
  logic armed;

  // prev tracks the level every cycle; armed opens the edge gates one cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= btn_clean;
      armed <= 1'b1;
    end
  end

  assign rise    = armed &  btn_clean & ~prev;
  assign fall    = armed & ~btn_clean &  prev;
  assign level_q = prev;

endmodule

// File: rtl/button_press_classifier.sv
// Turns the debounced button level into one-cycle gesture pulses:
// press/release on every edge, plus exactly one of click/double/long per gesture.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int LONG_MS   = 600,
  parameter int DOUBLE_MS = 300
) (
  input  logic                      clk,
  input  logic                      rst_n,
  button_press_classifier_if.slave  bus
);

  localparam int LONG_CYC   = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int DOUBLE_CYC = ms_to_cycles(CLK_HZ, DOUBLE_MS);
  localparam int MAX_CYC    = max_int(LONG_CYC, DOUBLE_CYC);
  localparam int TW         = $clog2(MAX_CYC + 1);

  // Timer values on the last cycle of each window; the pulse registers on that edge.
  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] DOUBLE_LAST = TW'(DOUBLE_CYC - 1);

  // Windows shorter than two cycles cannot be distinguished from a single edge.
  generate
    if (LONG_CYC < 2 || DOUBLE_CYC < 2) begin : g_bad_timing
      $error("button_press_classifier: LONG_CYC and DOUBLE_CYC must both be >= 2");
    end
  endgenerate

  logic rise;
  logic fall;
  logic level_q;

  btn_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_clean (bus.btn_clean),
    .rise      (rise),
    .fall      (fall),
    .level_q   (level_q)
  );

  btn_state_t    state;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          press_q;
  logic          release_q;
  logic          click_q;
  logic          double_q;
  logic          long_q;

  // Saturating increment: the timer idles at all-ones in long holds instead of wrapping
  // back through a threshold value.
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  // Gesture FSM with its dwell timer; the timer restarts on every state change.
  // Edge tests come before timer tests so a simultaneous edge wins the tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      press_q   <= rise;
      release_q <= fall;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      timer     <= timer_inc;
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_DOWN1;
            timer <= '0;
          end
        end
        ST_DOWN1: begin
          if (fall) begin
            state <= ST_GAP;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            long_q <= 1'b1;
            state  <= ST_LONGHOLD;
            timer  <= '0;
          end
        end
        ST_GAP: begin
          if (rise) begin
            double_q <= 1'b1;
            state    <= ST_DOWN2;
            timer    <= '0;
          end else if (timer == DOUBLE_LAST) begin
            click_q <= 1'b1;
            state   <= ST_IDLE;
            timer   <= '0;
          end
        end
        ST_DOWN2, ST_LONGHOLD: begin
          // Gesture already reported; just wait for the button to come up.
          if (fall) begin
            state <= ST_IDLE;
            timer <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.click_pulse   = click_q;
  assign bus.double_pulse  = double_q;
  assign bus.long_pulse    = long_q;
  assign bus.held          = level_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed gestures, boundary and reset cases,
// then random press/release runs, all checked every cycle against a timestamp model.
module tb_button_press_classifier;

  localparam int LONG_CYC   = 10;
  localparam int DOUBLE_CYC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  button_press_classifier_if bus ();

  button_press_classifier #(
    .CLK_HZ    (1000),
    .LONG_MS   (10),
    .DOUBLE_MS (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Reference model: a gesture is tracked by what phase it is in and the edge
  // number at which that phase began; thresholds are plain elapsed-edge tests.
  localparam int G_NONE = 0, G_FIRST_DOWN = 1, G_WAIT_SECOND = 2, G_SECOND_DOWN = 3, G_LONG = 4;
  int   gesture;
  int   since;
  int   edge_no;
  logic last_lvl;
  logic seen_edge;
  logic e_press, e_release, e_click, e_double, e_long, e_held;

  task automatic model_reset();
    gesture   = G_NONE;
    since     = 0;
    edge_no   = 0;
    last_lvl  = 1'b0;
    seen_edge = 1'b0;
    {e_press, e_release, e_click, e_double, e_long, e_held} = '0;
  endtask

  task automatic model_edge(input logic lvl);
    logic up, dn;
    up = seen_edge && lvl && !last_lvl;
    dn = seen_edge && !lvl && last_lvl;
    e_press = up; e_release = dn; e_held = lvl;
    e_click = 1'b0; e_double = 1'b0; e_long = 1'b0;
    if (gesture == G_NONE && up) begin
      gesture = G_FIRST_DOWN; since = edge_no;
    end else if (gesture == G_FIRST_DOWN) begin
      if (dn) begin
        gesture = G_WAIT_SECOND; since = edge_no;
      end else if (edge_no - since == LONG_CYC) begin
        e_long = 1'b1; gesture = G_LONG;
      end
    end else if (gesture == G_WAIT_SECOND) begin
      if (up) begin
        e_double = 1'b1; gesture = G_SECOND_DOWN;
      end else if (edge_no - since == DOUBLE_CYC) begin
        e_click = 1'b1; gesture = G_NONE;
      end
    end else if ((gesture == G_SECOND_DOWN || gesture == G_LONG) && dn) begin
      gesture = G_NONE;
    end
    last_lvl  = lvl;
    seen_edge = 1'b1;
    edge_no++;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".press"},   int'(bus.press_pulse),   int'(e_press));
    chk({ctx, ".release"}, int'(bus.release_pulse), int'(e_release));
    chk({ctx, ".click"},   int'(bus.click_pulse),   int'(e_click));
    chk({ctx, ".double"},  int'(bus.double_pulse),  int'(e_double));
    chk({ctx, ".long"},    int'(bus.long_pulse),    int'(e_long));
    chk({ctx, ".held"},    int'(bus.held),          int'(e_held));
    chk({ctx, ".excl"},
        int'((32'(bus.click_pulse) + 32'(bus.double_pulse) + 32'(bus.long_pulse)) <= 1), 1);
  endtask

  // Called at a negedge: drive level, let one edge pass, check on the next negedge.
  task automatic tick(input logic lvl, input string ctx);
    bus.btn_clean = lvl;
    @(posedge clk);
    model_edge(lvl);
    @(negedge clk);
    check_outputs(ctx);
  endtask

  task automatic ticks(input logic lvl, input int n, input string ctx);
    for (int i = 0; i < n; i++) tick(lvl, ctx);
  endtask

  // Asynchronous reset: outputs must be zero 1 ns after assertion, before any clock.
  task automatic do_reset(input logic lvl, input string ctx);
    bus.btn_clean = lvl;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({ctx, ".async"});
    repeat (2) @(negedge clk);
    check_outputs({ctx, ".hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    bus.btn_clean = 1'b0;
    model_reset();
    #2;
    do_reset(1'b0, "reset");

    // Single click: 3 high, then release and wait out the gap.
    ticks(1'b1, 3, "click");
    ticks(1'b0, 10, "click");

    // Double click: press 2, release 2, press 2, release.
    ticks(1'b1, 2, "dbl");
    ticks(1'b0, 2, "dbl");
    ticks(1'b1, 2, "dbl");
    ticks(1'b0, 10, "dbl");

    // Long press held well past the threshold.
    ticks(1'b1, 20, "long");
    ticks(1'b0, 10, "long");

    // Release lands on the long-threshold edge: click, not long.
    ticks(1'b1, LONG_CYC, "bnd_long");
    ticks(1'b0, 10, "bnd_long");

    // Second press lands on the gap-timeout edge: double, not click.
    ticks(1'b1, 2, "bnd_gap");
    ticks(1'b0, DOUBLE_CYC, "bnd_gap");
    ticks(1'b1, 2, "bnd_gap");
    ticks(1'b0, 10, "bnd_gap");

    // Button held through reset release: no press, release still reported.
    do_reset(1'b1, "rst_held");
    ticks(1'b1, 5, "rst_held");
    ticks(1'b0, 10, "rst_held");

    // Reset in the gap while release_pulse is high: pending click is dropped.
    ticks(1'b1, 3, "rst_gap");
    tick(1'b0, "rst_gap");
    chk("rst_gap.release_seen", int'(bus.release_pulse), 1);
    do_reset(1'b0, "rst_gap");
    ticks(1'b0, 10, "rst_gap");

    // Random runs of held/released with occasional resets.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 24) == 0) do_reset(1'($urandom_range(0, 1)), "rnd_rst");
      ticks(1'($urandom_range(0, 1)), $urandom_range(1, 14), "rnd");
    end
    ticks(1'b0, 10, "tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
